// File: rtl/pipe_skid_buf_pkg.sv
// Shared constants for the two-entry pipeline skid buffer.
// State encoding doubles as the held-entry count.
package pipe_skid_buf_pkg;

    localparam logic RST_LVL = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer between pipeline stages. in_ready,
// out_valid and out_data all come from registers; flush empties both entries.
//
// Handshake: a beat moves on a rising edge where valid & ready are both high.
// in_ready depends only on state, so upstream never sees a combinational path.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int             DW        = 32,
    parameter logic [DW-1:0]  RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    state_t        r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;

    state_t w_state_nxt;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_main_from_in;
    logic   w_main_from_skid;
    logic   w_skid_load;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ST_ONE;
                    w_main_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_from_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_TWO;
                    w_skid_load = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Skid entry moves up behind the departing main entry.
                if (w_out_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_LVL) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_LVL) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else if (flush) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_main_from_in) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_state;

    a_legal_state: assert property (@(posedge clk) disable iff (rst == RST_LVL)
        logic'(r_state == ST_EMPTY) | logic'(r_state == ST_ONE) | logic'(r_state == ST_TWO));

endmodule
